// File: rtl/mmcm_seq_pkg.sv
// Shared types and defaults for the MMCM reset sequencer.
// State encoding is exported on the STATE port, so it must stay fixed.
package mmcm_seq_pkg;

    typedef enum logic [1:0] {
        MMCM_RST  = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_CNT_W               = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold the terminal value n-1.
    function automatic int cnt_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mmcm_reset_sequencer_if.sv
// Status/lock bundle between the reset sequencer and the clocking block.
// master = sequencer side, slave = MMCM/core side.
interface mmcm_reset_sequencer_if
    import mmcm_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);

    logic             locked_in;
    logic             mmcm_rst;
    logic             sys_reset;
    seq_state_t       state;
    logic [CNT_W-1:0] loss_cnt;
    logic [CNT_W-1:0] timeout_cnt;

    modport master (
        input  locked_in,
        output mmcm_rst,
        output sys_reset,
        output state,
        output loss_cnt,
        output timeout_cnt
    );

    modport slave (
        output locked_in,
        input  mmcm_rst,
        input  sys_reset,
        input  state,
        input  loss_cnt,
        input  timeout_cnt
    );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser, async active-high reset to 0.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
    (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// MMCM reset pulse / lock qualification / system reset owner on CLKIN1.
// Optional lock timeout re-pulse: define MMCM_LOCK_TIMEOUT_EN.
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int CNT_W               = DEF_CNT_W
) (
    input  logic                   clkin1,
    input  logic                   async_reset,
    mmcm_reset_sequencer_if.master bus
);

`ifdef MMCM_LOCK_TIMEOUT_EN
    localparam int CNT_MAX = max2(
        max2(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES),
        LOCK_TIMEOUT_CYCLES);
`else
    localparam int CNT_MAX = max2(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES);
`endif
    localparam int CW = cnt_bits(CNT_MAX);

    localparam logic [CW-1:0] RP_LAST = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(LOCK_STABLE_CYCLES - 1);
`ifdef MMCM_LOCK_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    seq_state_t       state;
    seq_state_t       state_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             locked_s;
    logic             loss_inc;
    logic             mmcm_rst_q;
    logic             sys_reset_q;
    logic [CNT_W-1:0] loss_q;
`ifdef MMCM_LOCK_TIMEOUT_EN
    logic             tout_inc;
    logic [CNT_W-1:0] tout_q;
`endif

    sync_2ff #(.W(1)) u_lock_sync (
        .clk (clkin1),
        .rst (async_reset),
        .d   (bus.locked_in),
        .q   (locked_s)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        loss_inc = 1'b0;
`ifdef MMCM_LOCK_TIMEOUT_EN
        tout_inc = 1'b0;
`endif
        unique case (state)
            MMCM_RST: begin
                if (cnt == RP_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
`ifdef MMCM_LOCK_TIMEOUT_EN
                end else if (cnt == TO_LAST) begin
                    state_n  = MMCM_RST;
                    cnt_n    = '0;
                    tout_inc = 1'b1;
                end
`else
                end else begin
                    cnt_n = '0;
                end
`endif
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == ST_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!locked_s) begin
                    state_n  = MMCM_RST;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_n = MMCM_RST;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge clkin1 or posedge async_reset) begin
        if (async_reset) begin
            state       <= MMCM_RST;
            cnt         <= '0;
            mmcm_rst_q  <= 1'b1;
            sys_reset_q <= 1'b1;
            loss_q      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mmcm_rst_q  <= (state_n == MMCM_RST);
            sys_reset_q <= (state_n != RUN);
            if (loss_inc && (loss_q != '1)) begin
                loss_q <= loss_q + 1'b1;
            end
        end
    end

`ifdef MMCM_LOCK_TIMEOUT_EN
    always_ff @(posedge clkin1 or posedge async_reset) begin
        if (async_reset) begin
            tout_q <= '0;
        end else if (tout_inc && (tout_q != '1)) begin
            tout_q <= tout_q + 1'b1;
        end
    end

    assign bus.timeout_cnt = tout_q;
`else
    assign bus.timeout_cnt = '0;
`endif

    assign bus.state     = state;
    assign bus.mmcm_rst  = mmcm_rst_q;
    assign bus.sys_reset = sys_reset_q;
    assign bus.loss_cnt  = loss_q;

endmodule
